// File: rtl/ibex_pkg.sv
// Shared ibex types for the top-down performance counter bank.
// Holds the FSM state and issue-slot category encodings.
package ibex_pkg;

   typedef enum logic [1:0] {
      TdIdle = 2'd0,
      TdRun  = 2'd1,
      TdSnap = 2'd2
   } td_state_e;

   typedef enum logic [1:0] {
      TdRetire   = 2'd0,
      TdFrontend = 2'd1,
      TdBackend  = 2'd2,
      TdBadSpec  = 2'd3
   } td_cat_e;

   localparam int unsigned TdNumCatDefault = 4;

endpackage

// File: rtl/ibex_topdown_ctr.sv
// Single top-down event counter with clear, window restart,
// saturate/wrap selection and a sticky overflow flag.
module ibex_topdown_ctr #(
   parameter int unsigned Width    = 40,
   parameter bit          Saturate = 1'b1
) (
   input  logic             clk_i,
   input  logic             rst_i,
   input  logic             clr_i,
   input  logic             restart_i,
   input  logic             inc_i,
   output logic [Width-1:0] cnt_o,
   output logic             ovf_o
);

   logic [Width-1:0] cnt_d, cnt_q;
   logic             ovf_d, ovf_q;
   logic             at_max;

   assign at_max = &cnt_q;

   // Restart rebases to zero but keeps this cycle's increment.
   always_comb begin
      cnt_d = cnt_q;
      ovf_d = ovf_q;
      if (clr_i) begin
         cnt_d = '0;
         ovf_d = 1'b0;
      end else if (restart_i) begin
         cnt_d = Width'(inc_i);
      end else if (inc_i) begin
         if (at_max) begin
            ovf_d = 1'b1;
            cnt_d = Saturate ? cnt_q : '0;
         end else begin
            cnt_d = cnt_q + Width'(1);
         end
      end
   end

   always_ff @(posedge clk_i) begin
      if (rst_i) begin
         cnt_q <= '0;
         ovf_q <= 1'b0;
      end else begin
         cnt_q <= cnt_d;
         ovf_q <= ovf_d;
      end
   end

   assign cnt_o = cnt_q;
   assign ovf_o = ovf_q;

endmodule

// File: rtl/ibex_topdown_perf_ctr.sv
// Top-down perf counter bank: per-category + cycle counters, windowed
// and req/ack snapshots. Shadow bank built only with IBEX_TOPDOWN_SHADOW_EN.
module ibex_topdown_perf_ctr
   import ibex_pkg::*;
#(
   parameter int unsigned  NumChannels  = TdNumCatDefault,
   parameter int unsigned  CounterWidth = 40,
   parameter int unsigned  WindowLen    = 0,
   parameter bit           Saturate     = 1'b1,
   localparam int unsigned IdxW         = $clog2(NumChannels + 1)
) (
   input  logic                    clk_i,
   input  logic                    rst_i,
   input  logic                    en_i,
   input  logic                    clear_i,
   input  logic                    evt_valid_i,
   input  logic [IdxW-1:0]         evt_cat_i,
   input  logic                    snap_req_i,
   output logic                    snap_ack_o,
   output logic                    window_done_o,
   input  logic [IdxW-1:0]         rd_idx_i,
   output logic [CounterWidth-1:0] rd_data_o,
   output logic [NumChannels:0]    ovf_o,
   output logic                    cat_err_o
);

   localparam int unsigned NumCtr = NumChannels + 1;
   localparam int unsigned WinW   = (WindowLen > 0) ? $clog2(WindowLen + 1) : 1;
   localparam logic [IdxW-1:0] NumChIdx   = IdxW'(NumChannels);
   localparam logic [WinW-1:0] WinLast    = WinW'((WindowLen > 0) ? WindowLen - 1 : 0);
   localparam logic [WinW-1:0] WinRestart = WinW'((WindowLen > 1) ? 1 : 0);
   localparam bit              WinEn      = (WindowLen > 0);

   td_state_e         state_d, state_q;
   logic [WinW-1:0]   win_d, win_q;
   logic              win_snap_d, win_snap_q;
   logic              cat_err_d, cat_err_q;
   logic              active, expiry, restart;
   logic [NumCtr-1:0] inc;

   logic [CounterWidth-1:0] live [NumCtr];
   logic [CounterWidth-1:0] bank [NumCtr];

   assign active  = (state_q != TdIdle);
   assign expiry  = WinEn && (state_q == TdRun) && (win_q == WinLast);
   assign restart = (state_q == TdSnap) && win_snap_q;

   always_comb begin
      state_d    = state_q;
      win_snap_d = 1'b0;
      unique case (state_q)
         TdIdle: begin
            if (snap_req_i) state_d = TdSnap;
            else if (en_i)  state_d = TdRun;
         end
         TdRun: begin
            if (snap_req_i || expiry) begin
               state_d    = TdSnap;
               win_snap_d = expiry;
            end else if (!en_i) begin
               state_d = TdIdle;
            end
         end
         TdSnap:  state_d = en_i ? TdRun : TdIdle;
         default: state_d = TdIdle;
      endcase
   end

   // The window SNAP cycle is the first cycle of the next window;
   // a manual SNAP landing on the last slot defers expiry by holding.
   always_comb begin
      win_d = win_q;
      if (clear_i)                          win_d = '0;
      else if (restart)                     win_d = WinRestart;
      else if (active && (win_q != WinLast)) win_d = win_q + WinW'(1);
   end

   always_comb begin
      inc = '0;
      inc[NumChannels] = active;
      for (int i = 0; i < NumChannels; i++) begin
         inc[i] = active && evt_valid_i && (evt_cat_i == IdxW'(i));
      end
   end

   always_comb begin
      cat_err_d = cat_err_q;
      if (clear_i) cat_err_d = 1'b0;
      else if (active && evt_valid_i && (evt_cat_i >= NumChIdx)) cat_err_d = 1'b1;
   end

   always_ff @(posedge clk_i) begin
      if (rst_i) begin
         state_q    <= TdIdle;
         win_q      <= '0;
         win_snap_q <= 1'b0;
         cat_err_q  <= 1'b0;
      end else begin
         state_q    <= state_d;
         win_q      <= win_d;
         win_snap_q <= win_snap_d;
         cat_err_q  <= cat_err_d;
      end
   end

   for (genvar i = 0; i < NumCtr; i++) begin : g_ctr
      ibex_topdown_ctr #(
         .Width    (CounterWidth),
         .Saturate (Saturate)
      ) u_ctr (
         .clk_i     (clk_i),
         .rst_i     (rst_i),
         .clr_i     (clear_i),
         .restart_i (restart),
         .inc_i     (inc[i]),
         .cnt_o     (live[i]),
         .ovf_o     (ovf_o[i])
      );
   end

`ifdef IBEX_TOPDOWN_SHADOW_EN
   logic [CounterWidth-1:0] shadow_d [NumCtr];
   logic [CounterWidth-1:0] shadow_q [NumCtr];

   // Captures registered (pre-increment) live values.
   always_comb begin
      shadow_d = shadow_q;
      if (state_q == TdSnap) shadow_d = live;
   end

   always_ff @(posedge clk_i) begin
      if (rst_i) begin
         for (int i = 0; i < NumCtr; i++) shadow_q[i] <= '0;
      end else begin
         shadow_q <= shadow_d;
      end
   end

   assign bank = shadow_q;
`else
   assign bank = live;
`endif

   always_comb begin
      rd_data_o = '0;
      if (rd_idx_i <= NumChIdx) rd_data_o = bank[rd_idx_i];
   end

   assign snap_ack_o    = (state_q == TdSnap);
   assign window_done_o = (state_q == TdSnap) && win_snap_q;
   assign cat_err_o     = cat_err_q;

endmodule

// File: tb/tb_ibex_topdown_perf_ctr.sv
// Directed bench for ibex_topdown_perf_ctr: default, 8-bit sat/wrap
// and windowed instances share one stimulus bus.
module tb_ibex_topdown_perf_ctr;

`ifdef IBEX_TOPDOWN_SHADOW_EN
   localparam bit Shadow = 1'b1;
`else
   localparam bit Shadow = 1'b0;
`endif

   logic       clk = 1'b0;
   logic       rst_i, en_i, clear_i, evt_valid_i, snap_req_i;
   logic [2:0] evt_cat_i, rd_idx_i;

   logic        d_ack, d_done, d_err;
   logic [39:0] d_rd;
   logic [4:0]  d_ovf;
   logic        s_ack, s_done, s_err;
   logic [7:0]  s_rd;
   logic [4:0]  s_ovf;
   logic        w_ack, w_done, w_err;
   logic [7:0]  w_rd;
   logic [4:0]  w_ovf;
   logic        n_ack, n_done, n_err;
   logic [39:0] n_rd;
   logic [4:0]  n_ovf;

   int n_vec, n_bad;

   always #5 clk = ~clk;

   ibex_topdown_perf_ctr u_dut (
      .clk_i(clk), .rst_i(rst_i), .en_i(en_i), .clear_i(clear_i),
      .evt_valid_i(evt_valid_i), .evt_cat_i(evt_cat_i),
      .snap_req_i(snap_req_i), .snap_ack_o(d_ack), .window_done_o(d_done),
      .rd_idx_i(rd_idx_i), .rd_data_o(d_rd), .ovf_o(d_ovf), .cat_err_o(d_err)
   );

   ibex_topdown_perf_ctr #(.CounterWidth(8), .Saturate(1'b1)) u_sat (
      .clk_i(clk), .rst_i(rst_i), .en_i(en_i), .clear_i(clear_i),
      .evt_valid_i(evt_valid_i), .evt_cat_i(evt_cat_i),
      .snap_req_i(snap_req_i), .snap_ack_o(s_ack), .window_done_o(s_done),
      .rd_idx_i(rd_idx_i), .rd_data_o(s_rd), .ovf_o(s_ovf), .cat_err_o(s_err)
   );

   ibex_topdown_perf_ctr #(.CounterWidth(8), .Saturate(1'b0)) u_wrap (
      .clk_i(clk), .rst_i(rst_i), .en_i(en_i), .clear_i(clear_i),
      .evt_valid_i(evt_valid_i), .evt_cat_i(evt_cat_i),
      .snap_req_i(snap_req_i), .snap_ack_o(w_ack), .window_done_o(w_done),
      .rd_idx_i(rd_idx_i), .rd_data_o(w_rd), .ovf_o(w_ovf), .cat_err_o(w_err)
   );

   ibex_topdown_perf_ctr #(.WindowLen(16)) u_win (
      .clk_i(clk), .rst_i(rst_i), .en_i(en_i), .clear_i(clear_i),
      .evt_valid_i(evt_valid_i), .evt_cat_i(evt_cat_i),
      .snap_req_i(snap_req_i), .snap_ack_o(n_ack), .window_done_o(n_done),
      .rd_idx_i(rd_idx_i), .rd_data_o(n_rd), .ovf_o(n_ovf), .cat_err_o(n_err)
   );

   task automatic chk(input string tag, input logic [63:0] obs,
                      input logic [63:0] exp);
      n_vec++;
      if (obs !== exp) begin
         n_bad++;
         $display("FAIL %s: got %0d want %0d", tag, obs, exp);
      end
   endtask

   task automatic cyc();
      @(posedge clk);
      #1;
   endtask

   task automatic drv(input logic en, input logic v, input logic [2:0] cat,
                      input logic req, input logic clr);
      en_i        = en;
      evt_valid_i = v;
      evt_cat_i   = cat;
      snap_req_i  = req;
      clear_i     = clr;
   endtask

   task automatic rd_chk(input string tag, input logic [2:0] idx,
                         input logic [63:0] exp);
      rd_idx_i = idx;
      #1;
      chk(tag, 64'(d_rd), exp);
   endtask

   initial begin
      n_vec    = 0;
      n_bad    = 0;
      rst_i    = 1'b1;
      rd_idx_i = '0;
      drv(0, 0, 0, 0, 0);
      cyc(); cyc();

      // reset in the middle of RUN
      rst_i = 1'b0;
      drv(1, 0, 0, 0, 0); cyc();
      drv(1, 1, 3'd1, 0, 0); cyc(); cyc(); cyc();
      rst_i = 1'b1; cyc(); cyc();
      rst_i = 1'b0;
      drv(0, 0, 0, 0, 0);
      chk("rst_ovf", 64'(d_ovf), 0);
      chk("rst_err", 64'(d_err), 0);
      chk("rst_ack", 64'(d_ack), 0);
      rd_chk("rst_idx1", 1, 0);
      rd_chk("rst_idx4", 4, 0);
      drv(0, 1, 3'd1, 0, 0); cyc();
      rd_chk("idle_idx1", 1, 0);
      rd_chk("idle_idx4", 4, 0);

      // counting and req/ack snapshot
      drv(1, 0, 0, 0, 0); cyc();
      for (int k = 1; k <= 11; k++) begin
         drv(1, k <= 8, (k <= 3) ? 3'd0 : 3'd2, k == 11, 0);
         if (k == 11) chk("ack_early", 64'(d_ack), 0);
         cyc();
      end
      chk("ack", 64'(d_ack), 1);
      chk("ack_nowin", 64'(d_done), 0);
      drv(1, 0, 0, 0, 0); cyc();
      chk("ack_pulse", 64'(d_ack), 0);
      rd_chk("cnt_idx0", 0, 3);
      rd_chk("cnt_idx2", 2, 5);
      rd_chk("cnt_idx4", 4, Shadow ? 11 : 12);
      rd_chk("cnt_idx5", 5, 0);
      rd_chk("cnt_idx7", 7, 0);
      drv(0, 0, 0, 0, 0); cyc();

      // 8-bit overflow, saturate and wrap
      rst_i = 1'b1; cyc();
      rst_i = 1'b0;
      drv(1, 0, 0, 0, 0); cyc();
      rd_idx_i = 3'd1;
      drv(1, 1, 3'd1, 0, 0);
      repeat (255) cyc();
      chk("ovf255_sat", 64'(s_ovf), 0);
      chk("ovf255_wrap", 64'(w_ovf), 0);
      chk("sat_255", 64'(s_rd), Shadow ? 0 : 255);
      cyc();
      chk("ovf_sat", 64'(s_ovf), 64'b10010);
      chk("ovf_wrap", 64'(w_ovf), 64'b10010);
      drv(1, 0, 0, 1, 0); cyc();
      drv(0, 0, 0, 0, 0); cyc();
      rd_idx_i = 3'd1; #1;
      chk("sat_idx1", 64'(s_rd), 255);
      chk("wrap_idx1", 64'(w_rd), 0);
      chk("big_idx1", 64'(d_rd), 256);
      rd_idx_i = 3'd4; #1;
      chk("sat_idx4", 64'(s_rd), 255);
      chk("wrap_idx4", 64'(w_rd), Shadow ? 1 : 2);
      chk("big_ovf", 64'(d_ovf), 0);

      // 16-cycle window, cat0 every cycle
      rst_i = 1'b1; cyc();
      rst_i = 1'b0;
      drv(1, 1, 3'd0, 0, 0); cyc();
      for (int c = 0; c < 34; c++) begin
         chk($sformatf("win_done_c%0d", c), 64'(n_done), 64'(c == 16 || c == 32));
         chk($sformatf("win_ack_c%0d", c), 64'(n_ack), 64'(c == 16 || c == 32));
         if (c == 17 || c == 33) begin
            rd_idx_i = 3'd0; #1;
            chk($sformatf("win_idx0_c%0d", c), 64'(n_rd), Shadow ? 16 : 1);
            rd_idx_i = 3'd4; #1;
            chk($sformatf("win_idx4_c%0d", c), 64'(n_rd), Shadow ? 16 : 1);
         end
         cyc();
      end
      drv(0, 0, 0, 0, 0); cyc();

      // clear colliding with an event
      rst_i = 1'b1; cyc();
      rst_i = 1'b0;
      drv(1, 0, 0, 0, 0); cyc();
      drv(1, 1, 3'd3, 0, 0); repeat (4) cyc();
      drv(1, 0, 0, 1, 0); cyc();
      drv(1, 0, 0, 0, 0); cyc();
      rd_chk("pre_idx3", 3, 4);
      drv(1, 1, 3'd3, 0, 1); cyc();
      drv(1, 0, 0, 0, 0);
      rd_chk("clr_idx3", 3, Shadow ? 4 : 0);
      rd_chk("clr_idx4", 4, Shadow ? 5 : 0);
      drv(1, 0, 0, 1, 0); cyc();
      drv(1, 0, 0, 0, 0); cyc();
      rd_chk("post_idx3", 3, 0);
      rd_chk("post_idx4", 4, Shadow ? 1 : 2);

      // out-of-range category
      chk("err_before", 64'(d_err), 0);
      drv(1, 1, 3'd4, 0, 0); cyc();
      drv(1, 0, 0, 0, 0);
      chk("bad_err", 64'(d_err), 1);
      rd_chk("bad_idx0", 0, 0);
      rd_chk("bad_idx3", 3, 0);
      cyc(); cyc();
      chk("bad_sticky", 64'(d_err), 1);
      drv(1, 0, 0, 0, 1); cyc();
      drv(1, 0, 0, 0, 0);
      chk("bad_clr", 64'(d_err), 0);
      drv(1, 1, 3'd7, 0, 0); cyc();
      drv(0, 0, 0, 0, 0);
      chk("bad_err7", 64'(d_err), 1);
      cyc();

      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
      $finish;
   end

endmodule
